// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier with a valid/ready handshake on both sides.
// Define SHIFT_ADD_EARLY_TERM_EN to end the calculation as soon as no multiplier bits remain.
module seq_shift_add_multiplier #(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+N-1:0] product,
  output logic           busy
);

  localparam int W  = M + N;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  mcand;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_step;
  logic [N-1:0]  mplier;
  logic [N-1:0]  mplier_step;
  logic [CW-1:0] count;
  logic [CW-1:0] count_step;
  logic          calc_last;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CALC) || (state == DONE);
  assign out_valid = (state == DONE);

  always_comb begin
    acc_step    = mplier[0] ? (acc + mcand) : acc;
    mplier_step = mplier >> 1;
    count_step  = count + CW'(1);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    // Once the remaining multiplier is zero no further additions can happen.
    calc_last   = (count_step == LAST) || (mplier_step == {N{1'b0}});
`else
    calc_last   = (count_step == LAST);
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (calc_last) begin
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= {W{1'b0}};
      mplier  <= {N{1'b0}};
      acc     <= {W{1'b0}};
      count   <= {CW{1'b0}};
      product <= {W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= {W{1'b0}};
            count  <= {CW{1'b0}};
          end
        end
        CALC: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier_step;
          count  <= count_step;
          // product includes this cycle's final addition
          if (calc_last) begin
            product <= acc_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

Interface
REQ-001 SHALL provide parameter M, default 8, multiplicand width in bits (M >= 1).
REQ-002 SHALL provide parameter N, default 8, multiplier width in bits and maximum iteration count (N >= 1).
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide port in_valid  input  1  operands a/b valid.
REQ-006 SHALL provide port in_ready  output  1  block can accept operands.
REQ-007 SHALL provide port a  input  M  unsigned multiplicand.
REQ-008 SHALL provide port b  input  N  unsigned multiplier.
REQ-009 SHALL provide port out_valid  output  1  product valid.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts product.
REQ-011 SHALL provide port product  output  M+N  unsigned a*b.
REQ-012 SHALL provide port busy  output  1  high while in CALC or DONE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in CALC or DONE; out_valid SHALL be 1 only in DONE.
REQ-015 Acceptance SHALL occur on an edge where in_valid && in_ready: latch mcand = a zero-extended to M+N bits, mplier = b, acc = 0, count = 0, go to CALC.
REQ-016 Each CALC cycle SHALL: if mplier[0] then acc += mcand; mcand <<= 1; mplier >>= 1; count += 1.
REQ-017 CALC SHALL go to DONE on the edge where count reaches N; acc SHALL be copied to product on that edge.
REQ-018 Latency SHALL be N cycles from the accepting edge to the first cycle with out_valid high (Configuration excepted).
REQ-019 Accumulation SHALL be M+N bits wide; the full unsigned product SHALL never overflow or truncate.
REQ-020 DONE SHALL hold out_valid and product stable until out_ready is 1; on that edge SHALL go to IDLE.
REQ-021 product SHALL retain the last result after the handshake, until the next DONE entry or reset.
REQ-022 in_valid and operand changes while not in IDLE SHALL be ignored.
REQ-023 The minimum period between back-to-back acceptances SHALL be N+2 cycles when out_ready is held at 1.

Reset
REQ-024 On an edge with rst = 1: state = IDLE, product = 0, acc = 0, count = 0, out_valid = 0, busy = 0, in_ready = 1 (from the next cycle).
REQ-025 Reset in CALC or DONE SHALL abort the operation and discard the partial or pending result; no out_valid SHALL follow.
REQ-026 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-027 Macro SHIFT_ADD_EARLY_TERM_EN, when defined, SHALL end CALC at the end of any CALC cycle in which the post-shift mplier is zero, in addition to the count = N condition.
REQ-028 With SHIFT_ADD_EARLY_TERM_EN, latency SHALL be max(1, index of highest set bit of b + 1) cycles; b = 0 gives 1 cycle.
REQ-029 Without SHIFT_ADD_EARLY_TERM_EN, latency SHALL always be exactly N cycles, and product values SHALL be identical in both builds.

Verification
REQ-030 M=N=8, a=255, b=255, out_ready=1 -> product=0xFE01 (65025); out_valid high 8 cycles after acceptance, for 1 cycle.
REQ-031 M=N=8, a=200, b=0 -> product=0; latency 8 without the macro, 1 with it.
REQ-032 a=13, b=2, out_ready held 0 for 5 cycles in DONE -> product=26 held stable; in_ready=0; in_valid pulses ignored; IDLE after out_ready=1.
REQ-033 a=255, b=255, rst=1 on 3rd CALC cycle -> next cycle: product=0, out_valid=0, in_ready=1; no result is produced.
REQ-034 M=12, N=4, a=4095, b=15, then a=3, b=8 back-to-back -> products 61425 then 24; with the macro, second latency = 4.
